// File: rtl/mimo_fifo_rr.sv
// mimo_fifo_rr: per-lane first-word-fall-through FIFOs whose entries carry a destination
// port, with one round-robin arbiter and one registered valid/ready stage per output port.
module mimo_fifo_rr #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int NUM_IN  = 8,
    parameter int NUM_OUT = 8
) (
    input  logic                                i_clock,
    input  logic                                i_reset_n,
    input  logic [NUM_IN*WIDTH-1:0]             i_data,
    input  logic [NUM_IN*$clog2(NUM_OUT)-1:0]   i_to_branch,
    input  logic [NUM_IN-1:0]                   i_valid,
    output logic [NUM_IN-1:0]                   o_ready,
    output logic [NUM_OUT*WIDTH-1:0]            o_data,
    output logic [NUM_OUT-1:0]                  o_valid,
    input  logic [NUM_OUT-1:0]                  i_ready,
    output logic [NUM_IN-1:0]                   o_drop,
    output logic [NUM_IN*($clog2(DEPTH)+1)-1:0] o_level
);
    localparam int BW = $clog2(NUM_OUT);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = $clog2(NUM_IN);
    localparam int EW = BW + WIDTH;

    logic [EW-1:0]                 mem_q [NUM_IN][DEPTH];
    logic [NUM_IN-1:0][PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [NUM_IN-1:0][PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [NUM_IN-1:0][LW-1:0]     level_q, level_d;
    logic [NUM_OUT-1:0][IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_OUT-1:0][WIDTH-1:0] o_data_q, o_data_d;
    logic [NUM_OUT-1:0]            o_valid_q, o_valid_d;

    logic [NUM_IN-1:0][BW-1:0]     head_br;
    logic [NUM_IN-1:0][WIDTH-1:0]  head_data;
    logic [NUM_IN-1:0]             not_empty;
    logic [NUM_IN-1:0]             bad;
    logic [NUM_IN-1:0]             push;
    logic [NUM_IN-1:0]             pop;

    logic                          found;
    int unsigned                   idx;
    int unsigned                   gnt;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        assign head_br[k]   = mem_q[k][rd_ptr_q[k]][WIDTH +: BW];
        assign head_data[k] = mem_q[k][rd_ptr_q[k]][WIDTH-1:0];
        assign not_empty[k] = (level_q[k] != '0);
        assign o_ready[k]   = i_reset_n && (level_q[k] != LW'(DEPTH));
        // An out-of-range branch can only exist when NUM_OUT leaves spare codes in BW bits.
        if (NUM_OUT < (1 << BW)) begin : g_range
            assign bad[k] = not_empty[k] && (32'(head_br[k]) >= 32'(NUM_OUT));
        end else begin : g_no_range
            assign bad[k] = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {i_to_branch[k*BW +: BW], i_data[k*WIDTH +: WIDTH]};
            end
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        rr_ptr_d  = rr_ptr_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        push      = '0;
        pop       = bad;
        found     = 1'b0;
        idx       = 0;
        gnt       = 0;

        // Each head addresses a single port, so grants from different ports never collide.
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (!o_valid_q[j] || i_ready[j]) begin
                found = 1'b0;
                gnt   = 0;
                for (int unsigned off = 0; off < NUM_IN; off++) begin
                    idx = 32'(rr_ptr_q[j]) + off;
                    if (idx >= NUM_IN) idx = idx - NUM_IN;
                    if (!found && not_empty[idx] && !bad[idx] && (32'(head_br[idx]) == j)) begin
                        found = 1'b1;
                        gnt   = idx;
                    end
                end
                o_valid_d[j] = found;
                if (found) begin
                    pop[gnt]    = 1'b1;
                    o_data_d[j] = head_data[gnt];
                    rr_ptr_d[j] = (gnt == NUM_IN - 1) ? '0 : IW'(gnt + 1);
                end
            end
        end

        for (int unsigned k = 0; k < NUM_IN; k++) begin
            push[k] = i_valid[k] && o_ready[k];
            if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
            if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            if (push[k] && !pop[k]) begin
                level_d[k] = level_q[k] + LW'(1);
            end else if (!push[k] && pop[k]) begin
                level_d[k] = level_q[k] - LW'(1);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            rr_ptr_q  <= '0;
            o_data_q  <= '0;
            o_valid_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            rr_ptr_q  <= rr_ptr_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_drop  = bad;
    assign o_level = level_q;

endmodule
